// File: rtl/tmds_multi_encoder.sv
// Multi-channel TMDS encoder for the char_display HDMI/DVI output path.
// All data channels are encoded in lock-step from a shared period mode.
// Supported periods are control, video (DVI 1.0 8b/10b with running
// disparity), video guard band, TERC4 data island and data-island guard band.
//
// Ports:
//   i_clk      pixel clock
//   i_rst      synchronous active-high reset (takes priority over i_ce)
//   i_ce       clock enable; pipeline, bias and outputs hold while low
//   i_mode     period type: 0 CTRL, 1 VIDEO, 2 VID_GUARD, 3 TERC4,
//              4 DI_GUARD, 5-7 illegal
//   i_data     pixel byte per channel, channel n at [8n+7:8n]
//   i_ctrl     {c1,c0} per channel, channel n at [2n+1:2n]
//   i_terc4    data-island nibble per channel, channel n at [4n+3:4n]
//   o_tmds     10-bit symbol per channel, channel n at [10n+9:10n]
//   o_bias     signed running disparity per channel
//   o_mode_err sticky flag, set once an illegal mode reaches the output stage
module tmds_multi_encoder #(
    parameter int CHANNELS = 3,
    parameter int PIPELINE = 1,
    parameter int BIAS_W   = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_ce,
    input  logic [2:0]                 i_mode,
    input  logic [8*CHANNELS-1:0]      i_data,
    input  logic [2*CHANNELS-1:0]      i_ctrl,
    input  logic [4*CHANNELS-1:0]      i_terc4,
    output logic [10*CHANNELS-1:0]     o_tmds,
    output logic [BIAS_W*CHANNELS-1:0] o_bias,
    output logic                       o_mode_err
);

    localparam logic [2:0] MODE_CTRL      = 3'd0;
    localparam logic [2:0] MODE_VIDEO     = 3'd1;
    localparam logic [2:0] MODE_VID_GUARD = 3'd2;
    localparam logic [2:0] MODE_TERC4     = 3'd3;
    localparam logic [2:0] MODE_DI_GUARD  = 3'd4;

    localparam logic [9:0] SYM_CTRL00  = 10'b1101010100;
    localparam logic [9:0] GUARD_EVEN  = 10'b1011001100;
    localparam logic [9:0] GUARD_ODD   = 10'b0100110011;

    localparam logic [BIAS_W-1:0] BIAS_ZERO = '0;
    localparam logic [BIAS_W-1:0] BIAS_TWO  = BIAS_W'(2);
    localparam logic [BIAS_W-1:0] BIAS_EIGHT = BIAS_W'(8);

    // Output-stage view of the inputs (registered or straight through)
    logic [2:0]                 s_mode;
    logic [8*CHANNELS-1:0]      s_data;
    logic [2*CHANNELS-1:0]      s_ctrl;
    logic [4*CHANNELS-1:0]      s_terc4;

    logic [10*CHANNELS-1:0]     tmds_q;
    logic [BIAS_W*CHANNELS-1:0] bias_q;
    logic                       mode_err_q;
    logic [10*CHANNELS-1:0]     tmds_d;
    logic [BIAS_W*CHANNELS-1:0] bias_d;

    generate
        if (PIPELINE != 0) begin : g_pipe
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    s_mode  <= MODE_CTRL;
                    s_data  <= '0;
                    s_ctrl  <= '0;
                    s_terc4 <= '0;
                end else if (i_ce) begin
                    s_mode  <= i_mode;
                    s_data  <= i_data;
                    s_ctrl  <= i_ctrl;
                    s_terc4 <= i_terc4;
                end
            end
        end else begin : g_direct
            assign s_mode  = i_mode;
            assign s_data  = i_data;
            assign s_ctrl  = i_ctrl;
            assign s_terc4 = i_terc4;
        end
    endgenerate

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] terc4_sym(input logic [3:0] n);
        case (n)
            4'h0:    return 10'b1010011100;
            4'h1:    return 10'b1001100011;
            4'h2:    return 10'b1011100100;
            4'h3:    return 10'b1011100010;
            4'h4:    return 10'b0101110001;
            4'h5:    return 10'b0100011110;
            4'h6:    return 10'b0110001110;
            4'h7:    return 10'b0100111100;
            4'h8:    return 10'b1011001100;
            4'h9:    return 10'b0100111001;
            4'hA:    return 10'b0110011100;
            4'hB:    return 10'b1011000110;
            4'hC:    return 10'b1010001110;
            4'hD:    return 10'b1001110001;
            4'hE:    return 10'b0101100011;
            default: return 10'b1011000011;
        endcase
    endfunction

    // DVI 1.0 video encode; returns {next_bias, symbol}
    function automatic logic [BIAS_W+9:0] video_enc(input logic [7:0] d,
                                                   input logic [BIAS_W-1:0] bias);
        logic [3:0]        n1;
        logic [3:0]        nq;
        logic              use_xnor;
        logic [8:0]        qm;
        logic [BIAS_W-1:0] bal;
        logic [BIAS_W-1:0] nb;
        logic [9:0]        sym;
        n1 = '0;
        for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, d[i]};
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~use_xnor;
        nq = '0;
        for (int i = 0; i < 8; i++) nq = nq + {3'b000, qm[i]};
        // ones - zeros = 2*ones - 8, in two's complement
        bal = (BIAS_W'(nq) << 1) - BIAS_EIGHT;
        if ((bias == BIAS_ZERO) || (bal == BIAS_ZERO)) begin
            if (!qm[8]) begin
                sym = {2'b10, ~qm[7:0]};
                nb  = bias - bal;
            end else begin
                sym = {2'b01, qm[7:0]};
                nb  = bias + bal;
            end
        end else if (bias[BIAS_W-1] == bal[BIAS_W-1]) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            nb  = bias + (qm[8] ? BIAS_TWO : BIAS_ZERO) - bal;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            nb  = bias - (qm[8] ? BIAS_ZERO : BIAS_TWO) + bal;
        end
        return {nb, sym};
    endfunction

    // Every non-video period clears the disparity, hence the zero default
    always_comb begin
        tmds_d = '0;
        bias_d = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            case (s_mode)
                MODE_CTRL:
                    tmds_d[10*ch +: 10] = ctrl_sym(s_ctrl[2*ch +: 2]);
                MODE_VIDEO:
                    {bias_d[BIAS_W*ch +: BIAS_W], tmds_d[10*ch +: 10]} =
                        video_enc(s_data[8*ch +: 8], bias_q[BIAS_W*ch +: BIAS_W]);
                MODE_VID_GUARD:
                    tmds_d[10*ch +: 10] = ((ch % 2) == 0) ? GUARD_EVEN : GUARD_ODD;
                MODE_TERC4:
                    tmds_d[10*ch +: 10] = terc4_sym(s_terc4[4*ch +: 4]);
                MODE_DI_GUARD:
                    // Channel 0 carries HSYNC/VSYNC in its guard symbol
                    tmds_d[10*ch +: 10] = (ch == 0) ? terc4_sym({2'b11, s_ctrl[1:0]})
                                                    : GUARD_ODD;
                default:
                    tmds_d[10*ch +: 10] = SYM_CTRL00;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmds_q     <= {CHANNELS{SYM_CTRL00}};
            bias_q     <= '0;
            mode_err_q <= 1'b0;
        end else if (i_ce) begin
            tmds_q <= tmds_d;
            bias_q <= bias_d;
            if (s_mode > MODE_DI_GUARD) mode_err_q <= 1'b1;
        end
    end

    assign o_tmds     = tmds_q;
    assign o_bias     = bias_q;
    assign o_mode_err = mode_err_q;

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// Bench for tmds_multi_encoder with CHANNELS=3, PIPELINE=1, BIAS_W=5.
// A per-cycle reference model (integer disparity, table lookups) predicts
// {o_mode_err, o_bias, o_tmds}; directed tables and sequences pin down the
// guard/TERC4 symbols, the video disparity corner and the sticky error flag.
module tb_tmds_multi_encoder;

    localparam int CH = 3;
    localparam int BW = 5;
    localparam int W  = 1 + BW*CH + 10*CH;

    localparam logic [9:0] CTRL00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TAB [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    localparam logic [9:0] TERC4_TAB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    typedef struct packed {
        logic [2:0]  mode;
        logic [23:0] data;
        logic [5:0]  ctrl;
        logic [11:0] terc4;
    } in_t;

    typedef struct {
        logic [2:0]  mode;
        logic [23:0] data;
        logic [5:0]  ctrl;
        logic [11:0] terc4;
        logic [29:0] exp_tmds;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b1;
    logic [2:0]    mode = 3'd0;
    logic [23:0]   data = '0;
    logic [5:0]    ctrl = '0;
    logic [11:0]   terc4 = '0;
    logic [29:0]   tmds;
    logic [14:0]   bias;
    logic          mode_err;

    int errors = 0;
    int checks = 0;

    // Model state
    in_t         pend[$];
    logic [W-1:0] exp_q[$];
    logic [29:0] m_tmds;
    int          m_bias[CH];
    logic        m_err;

    tmds_multi_encoder #(.CHANNELS(CH), .PIPELINE(1), .BIAS_W(BW)) dut (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_mode(mode), .i_data(data),
        .i_ctrl(ctrl), .i_terc4(terc4), .o_tmds(tmds), .o_bias(bias),
        .o_mode_err(mode_err));

    // Clock
    always #5 clk = ~clk;

    function automatic in_t mk(input logic [2:0] m, input logic [23:0] d,
                               input logic [5:0] c, input logic [11:0] t);
        in_t x;
        x.mode = m; x.data = d; x.ctrl = c; x.terc4 = t;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference video encoder working on integer disparity
    task automatic ref_video(input logic [7:0] d, inout int b, output logic [9:0] sym);
        int n1, nq, bal;
        bit xn;
        bit [8:0] qm;
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? !(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        nq = $countones(qm[7:0]);
        bal = nq - (8 - nq);
        if (b == 0 || bal == 0) begin
            if (qm[8] == 1'b0) begin sym = {2'b10, ~qm[7:0]}; b = b - bal; end
            else begin sym = {2'b01, qm[7:0]}; b = b + bal; end
        end else if ((b > 0) == (bal > 0)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            b = b + (qm[8] ? 2 : 0) - bal;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            b = b - (qm[8] ? 0 : 2) + bal;
        end
    endtask

    task automatic model_apply(input in_t x);
        logic [9:0] s;
        int b;
        for (int c = 0; c < CH; c++) begin
            b = m_bias[c];
            case (x.mode)
                3'd0: begin s = CTRL_TAB[x.ctrl[2*c +: 2]]; b = 0; end
                3'd1: ref_video(x.data[8*c +: 8], b, s);
                3'd2: begin s = (c % 2 == 0) ? 10'b1011001100 : 10'b0100110011; b = 0; end
                3'd3: begin s = TERC4_TAB[x.terc4[4*c +: 4]]; b = 0; end
                3'd4: begin
                    s = (c == 0) ? TERC4_TAB[{2'b11, x.ctrl[1:0]}] : 10'b0100110011;
                    b = 0;
                end
                default: begin s = CTRL00; b = 0; m_err = 1'b1; end
            endcase
            m_tmds[10*c +: 10] = s;
            m_bias[c] = b;
        end
    endtask

    function automatic logic [W-1:0] model_word();
        logic [14:0] eb;
        for (int c = 0; c < CH; c++) eb[5*c +: 5] = 5'(m_bias[c]);
        return {m_err, eb, m_tmds};
    endfunction

    // Driver: one clock edge, then model update and full-output compare
    task automatic step(input logic rst_v, input logic ce_v, input in_t x);
        logic [W-1:0] e;
        @(negedge clk);
        rst = rst_v; ce = ce_v;
        mode = x.mode; data = x.data; ctrl = x.ctrl; terc4 = x.terc4;
        @(posedge clk);
        if (rst_v) begin
            pend.delete();
            pend.push_back(mk(3'd0, '0, '0, '0));
            m_tmds = {CH{CTRL00}};
            for (int c = 0; c < CH; c++) m_bias[c] = 0;
            m_err = 1'b0;
        end else if (ce_v) begin
            pend.push_back(x);
            model_apply(pend.pop_front());
        end
        exp_q.push_back(model_word());
        #1;
        e = exp_q.pop_front();
        check("cycle", 64'({mode_err, bias, tmds}), 64'(e));
    endtask

    function automatic in_t rnd_in(input logic [2:0] m);
        return mk(m, 24'($urandom), 6'($urandom), 12'($urandom));
    endfunction

    vec_t tbl[7];

    initial begin
        // Stimulus table: non-video periods, expected {lane2, lane1, lane0}
        tbl[0] = '{3'd2, 24'h0, 6'b000000, 12'h000,
                   {10'b1011001100, 10'b0100110011, 10'b1011001100}};
        tbl[1] = '{3'd3, 24'h0, 6'b000000, 12'hF85,
                   {10'b1011000011, 10'b1011001100, 10'b0100011110}};
        tbl[2] = '{3'd4, 24'h0, 6'b000010, 12'h000,
                   {10'b0100110011, 10'b0100110011, 10'b0101100011}};
        tbl[3] = '{3'd0, 24'h0, 6'b111000, 12'h000,
                   {10'b1010101011, 10'b0101010100, 10'b1101010100}};
        tbl[4] = '{3'd3, 24'h0, 6'b000000, 12'h210,
                   {10'b1011100100, 10'b1001100011, 10'b1010011100}};
        tbl[5] = '{3'd3, 24'h0, 6'b000000, 12'hCA9,
                   {10'b1010001110, 10'b0110011100, 10'b0100111001}};
        tbl[6] = '{3'd4, 24'h0, 6'b111101, 12'h000,
                   {10'b0100110011, 10'b0100110011, 10'b1001110001}};

        // Reset, two cycles
        step(1'b1, 1'b1, mk(3'd0, '0, '0, '0));
        step(1'b1, 1'b1, mk(3'd0, '0, '0, '0));
        check("reset_tmds", 64'(tmds), 64'({CH{CTRL00}}));
        check("reset_bias", 64'(bias), 64'd0);
        check("reset_err", 64'(mode_err), 64'd0);

        // Dirty the state, then reset with ce low
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, rnd_in(3'd1));
        step(1'b1, 1'b0, rnd_in(3'd1));
        check("reset_noce_tmds", 64'(tmds), 64'({CH{CTRL00}}));
        check("reset_noce_bias", 64'(bias), 64'd0);

        // Video 00 twice from zero disparity, then CTRL 01, then video 00
        step(1'b0, 1'b1, mk(3'd1, 24'h0, 6'b0, 12'h0));
        step(1'b0, 1'b1, mk(3'd1, 24'h0, 6'b0, 12'h0));
        check("vid00_first_sym", 64'(tmds[9:0]), 64'(10'b0100000000));
        check("vid00_first_bias", 64'(bias[4:0]), 64'(5'b11000));
        step(1'b0, 1'b1, mk(3'd0, 24'h0, 6'b010101, 12'h0));
        check("vid00_second_sym", 64'(tmds[9:0]), 64'(10'b1111111111));
        check("vid00_second_bias", 64'(bias[4:0]), 64'(5'd2));
        step(1'b0, 1'b1, mk(3'd1, 24'h0, 6'b0, 12'h0));
        check("ctrl01_sym", 64'(tmds[9:0]), 64'(10'b0010101011));
        check("ctrl01_bias", 64'(bias), 64'd0);
        step(1'b0, 1'b1, mk(3'd0, 24'h0, 6'b0, 12'h0));
        check("vid00_after_ctrl", 64'(tmds[9:0]), 64'(10'b0100000000));

        // Table vectors back to back: result of vector i shows after step i+1
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) step(1'b0, 1'b1, mk(tbl[i].mode, tbl[i].data, tbl[i].ctrl, tbl[i].terc4));
            else       step(1'b0, 1'b1, mk(3'd0, '0, '0, '0));
            if (i > 0) begin
                check($sformatf("tbl%0d_tmds", i - 1), 64'(tmds), 64'(tbl[i-1].exp_tmds));
                check($sformatf("tbl%0d_bias", i - 1), 64'(bias), 64'd0);
            end
        end

        // Random legal traffic with random clock-enable gaps
        for (int i = 0; i < 400; i++)
            step(1'b0, ($urandom_range(0, 4) != 0), rnd_in(3'($urandom_range(0, 4))));

        // Long video stream with a 3-cycle enable gap in the middle
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rnd_in(3'd1));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, rnd_in(3'($urandom_range(0, 7))));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rnd_in(3'd1));

        // Illegal mode for one symbol, then back to video
        step(1'b0, 1'b1, rnd_in(3'd6));
        step(1'b0, 1'b1, rnd_in(3'd1));
        check("illegal_sym", 64'(tmds), 64'({CH{CTRL00}}));
        check("illegal_bias", 64'(bias), 64'd0);
        check("illegal_err_set", 64'(mode_err), 64'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rnd_in(3'd1));
        check("illegal_err_sticky", 64'(mode_err), 64'd1);
        step(1'b1, 1'b1, rnd_in(3'd1));
        check("err_cleared_by_reset", 64'(mode_err), 64'd0);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
